// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WAIT_CNT_W = 4;
  localparam int WORD_W     = 32;

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 storage; write and registered read land on the same edge.
// Read register can be cleared so write/error responses present zero data; contents never reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [WORD_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_clr) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accept in IDLE, WAIT_CYCLES wait states, one-cycle response pulse.
// Latency 1+WAIT_CYCLES (1 for illegal requests); stall holds the pipeline while a request is in flight.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int   AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic W_ZERO = (WAIT_CYCLES == 0);

  dmem_state_t           r_state;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [AW-1:0]         r_idx;
  logic [WORD_W-1:0]     r_wdata;
  logic                  r_wr;
  logic                  r_err;
  logic                  r_vld;

  logic              w_idle;
  logic              w_req;
  logic              w_illegal;
  logic              w_wait_done;
  logic              w_enter_resp;
  logic              w_fire;
  logic              w_is_wr;
  logic [AW-1:0]     w_arr_idx;
  logic [WORD_W-1:0] w_arr_wdata;
  logic              w_arr_we;
  logic              w_arr_re;
  logic              w_arr_clr;

  assign w_idle      = (r_state == IDLE);
  assign w_req       = req_rd | req_wr;
  assign w_illegal   = (req_addr[1:0] != 2'b00) |
                       (req_addr[31:2] >= 30'(DEPTH_WORDS)) |
                       (req_rd & req_wr);
  assign w_wait_done = (r_state == WAIT) & (r_cnt == WAIT_CNT_W'(1));

  // With zero wait states the access happens on the accept edge, so the array
  // must see the live request rather than the latched copy.
  assign w_enter_resp = (w_idle & w_req & (w_illegal | W_ZERO)) | w_wait_done;
  assign w_fire       = (w_idle & w_req & ~w_illegal & W_ZERO) | w_wait_done;
  assign w_is_wr      = w_idle ? req_wr : r_wr;
  assign w_arr_idx    = w_idle ? req_addr[AW+1:2] : r_idx;
  assign w_arr_wdata  = w_idle ? req_wdata : r_wdata;

  assign w_arr_we  = w_fire & w_is_wr;
  assign w_arr_re  = w_fire & ~w_is_wr;
  assign w_arr_clr = w_enter_resp & ~w_arr_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx   <= req_addr[AW+1:2];
            r_wdata <= req_wdata;
            r_wr    <= req_wr;
            r_cnt   <= WAIT_CNT_W'(WAIT_CYCLES);
            if (w_illegal | W_ZERO) begin
              r_state <= RESP;
              r_vld   <= 1'b1;
              r_err   <= w_illegal;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - WAIT_CNT_W'(1);
          if (r_cnt == WAIT_CNT_W'(1)) begin
            r_state <= RESP;
            r_vld   <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_clr   (w_arr_clr),
    .i_addr  (w_arr_idx),
    .i_wdata (w_arr_wdata),
    .o_rdata (resp_rdata)
  );

  assign req_ready  = w_idle;
  assign stall      = (w_idle & w_req) | (r_state == WAIT);
  assign resp_valid = r_vld;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: unit 0 runs with 2 wait states, unit 1 with none, both checked against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst   [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        stl   [2];
  logic        vld   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] mdl       [2][DEPTH];
  logic [31:0] last_data [2];
  logic        last_err  [2];

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_rd(rd[0]), .req_wr(wr[0]), .req_addr(addr[0]),
    .req_wdata(wdata[0]), .req_ready(ready[0]), .stall(stl[0]), .resp_valid(vld[0]),
    .resp_rdata(rdata[0]), .resp_err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_rd(rd[1]), .req_wr(wr[1]), .req_addr(addr[1]),
    .req_wdata(wdata[1]), .req_ready(ready[1]), .stall(stl[1]), .resp_valid(vld[1]),
    .resp_rdata(rdata[1]), .resp_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: accept cycle, wait cycles, response cycle.
  task automatic xact(input int u, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int          nwait;
    int          lat;
    logic [29:0] widx;
    logic        legal;
    logic [31:0] exp_d;
    nwait = (u == 0) ? 2 : 0;
    widx  = a[31:2];
    legal = (a[1:0] == 2'b00) && (widx < 30'(DEPTH)) && !(r && w);
    lat   = legal ? 1 + nwait : 1;
    exp_d = (legal && r) ? mdl[u][widx[9:0]] : 32'h0;

    @(posedge clk); #1;
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    @(negedge clk);
    chk($sformatf("u%0d accept ready", u), 32'(ready[u]), 32'd1);
    chk($sformatf("u%0d accept stall", u), 32'(stl[u]), 32'd1);
    chk($sformatf("u%0d accept valid", u), 32'(vld[u]), 32'd0);
    chk($sformatf("u%0d hold rdata", u), rdata[u], last_data[u]);
    chk($sformatf("u%0d hold err", u), 32'(err[u]), 32'(last_err[u]));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d c%0d ready", u, k), 32'(ready[u]), 32'd0);
      if (k < lat) begin
        chk($sformatf("u%0d c%0d valid", u, k), 32'(vld[u]), 32'd0);
        chk($sformatf("u%0d c%0d stall", u, k), 32'(stl[u]), 32'd1);
        chk($sformatf("u%0d c%0d err hold", u, k), 32'(err[u]), 32'(last_err[u]));
      end else begin
        chk($sformatf("u%0d resp valid a=%h", u, a), 32'(vld[u]), 32'd1);
        chk($sformatf("u%0d resp stall", u), 32'(stl[u]), 32'd0);
        chk($sformatf("u%0d resp err a=%h", u, a), 32'(err[u]), legal ? 32'd0 : 32'd1);
        chk($sformatf("u%0d resp rdata a=%h", u, a), rdata[u], exp_d);
      end
    end
    rd[u] = 1'b0; wr[u] = 1'b0;
    if (legal && w) mdl[u][widx[9:0]] = d;
    last_data[u] = exp_d;
    last_err[u]  = !legal;
    @(negedge clk);
    chk($sformatf("u%0d post valid", u), 32'(vld[u]), 32'd0);
    chk($sformatf("u%0d post ready", u), 32'(ready[u]), 32'd1);
    chk($sformatf("u%0d post rdata hold", u), rdata[u], last_data[u]);
  endtask

  task automatic rand_xact(input int u);
    int          kind;
    int          sel;
    logic [31:0] a;
    logic [31:0] d;
    kind = $urandom_range(0, 9);
    sel  = $urandom_range(0, 32);
    a    = (sel == 32) ? 32'h0000_0FFC : 32'(sel) << 2;
    d    = $urandom;
    case (kind)
      0, 1, 2, 3: xact(u, 1'b1, 1'b0, a, d);
      4, 5, 6:    xact(u, 1'b0, 1'b1, a, d);
      7:          xact(u, 1'b1, 1'b1, a, d);
      8:          xact(u, kind[0], ~kind[0], a | 32'($urandom_range(1, 3)), d);
      default: begin
        a = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | a) : ((32'(DEPTH) + 32'($urandom_range(0, 4000))) << 2);
        xact(u, $urandom_range(0, 1) == 1, 1'b1, a, d);
      end
    endcase
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
      last_data[u] = '0; last_err[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset ready", u), 32'(ready[u]), 32'd1);
      chk($sformatf("u%0d reset stall", u), 32'(stl[u]), 32'd0);
      chk($sformatf("u%0d reset valid", u), 32'(vld[u]), 32'd0);
      chk($sformatf("u%0d reset rdata", u), rdata[u], 32'd0);
      chk($sformatf("u%0d reset err", u), 32'(err[u]), 32'd0);
    end

    // Seed the region used by the random phase, plus the last word.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 32; i++) xact(u, 1'b0, 1'b1, 32'(i) << 2, $urandom);
      xact(u, 1'b0, 1'b1, 32'h0000_0FFC, $urandom);
    end

    xact(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    xact(0, 1'b1, 1'b0, 32'h10, 32'h0);
    xact(1, 1'b1, 1'b0, 32'h10, 32'h0);
    xact(1, 1'b1, 1'b0, 32'h0FFC, 32'h0);
    for (int u = 0; u < 2; u++) begin
      xact(u, 1'b1, 1'b0, 32'h13, 32'h0);
      xact(u, 1'b0, 1'b1, 32'h1000, 32'h5555_AAAA);
      xact(u, 1'b1, 1'b0, 32'h0, 32'h0);
      xact(u, 1'b1, 1'b1, 32'h20, 32'h1234);
      xact(u, 1'b1, 1'b0, 32'h20, 32'h0);
    end

    // Reset while a write sits in its wait states: the write must be dropped.
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst[0] = 1'b1; wr[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rst mid ready", 32'(ready[0]), 32'd1);
    chk("rst mid stall", 32'(stl[0]), 32'd0);
    chk("rst mid valid", 32'(vld[0]), 32'd0);
    chk("rst mid rdata", rdata[0], 32'd0);
    last_data[0] = '0; last_err[0] = 1'b0;
    xact(0, 1'b1, 1'b0, 32'h40, 32'h0);

    for (int n = 0; n < 150; n++) begin
      rand_xact(0);
      rand_xact(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU's MEM-stage data-memory port. Accepts one read or write request at a time from the EX/MEM stage. Inserts a configurable number of wait states and drives a stall to the pipeline while a request is in flight. Returns read data or an error with a one-cycle response pulse. Replaces the zero-latency data memory, so the pipeline can be exercised against slow memory.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words stored; power of two.
- `WAIT_CYCLES`, default 2: wait states inserted before each access; legal range 0..15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_rd`, input, 1: read request (MemRead from EX/MEM).
- `req_wr`, input, 1: write request (MemWrite from EX/MEM).
- `req_addr`, input, 32: byte address (ALU result).
- `req_wdata`, input, 32: store data (RD2 from EX/MEM).
- `req_ready`, output, 1: high when in IDLE, so a request is accepted this cycle.
- `stall`, output, 1: freeze IF/ID/EX/MEM stages.
- `resp_valid`, output, 1: one-cycle response pulse.
- `resp_rdata`, output, 32: read data, valid with `resp_valid`.
- `resp_err`, output, 1: request rejected, valid with `resp_valid`.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - A request is present when `req_rd | req_wr`. It is accepted when present in IDLE.
  - On acceptance, latch `req_addr`, `req_wdata`, and the type.
  - Load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES` > 0, otherwise RESP.
- **Error check** (combinational at acceptance). The request is illegal if any of these hold:
  - `req_addr[1:0] != 0`;
  - word index `req_addr[31:2] >= DEPTH_WORDS`;
  - `req_rd & req_wr`.
  - An illegal request goes directly to RESP with `resp_err=1`, regardless of `WAIT_CYCLES`.
  - An illegal request performs no array write, and `resp_rdata` is 0.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - The WAIT dwell is exactly `WAIT_CYCLES` cycles.
- **Entering RESP** (same edge):
  - A legal write stores `req_wdata` at the word index.
  - A legal read registers the array word into `resp_rdata`.
  - For a write, `resp_rdata` = 0.
- **RESP**
  - `resp_valid=1` for exactly one cycle, then IDLE.
  - `resp_rdata` and `resp_err` hold their values until the next response.
- **Stall**
  - `stall = (state==IDLE & (req_rd|req_wr)) | state==WAIT`.
  - `stall` is low in RESP, so the pipeline advances on the response cycle.
- The CPU holds the request stable while `stall` is high. The responder ignores request inputs outside IDLE.
- A request still asserted in the cycle after RESP is treated as a new request; the CPU must have advanced.
- **Reset**
  - Reset mid-operation returns the FSM to IDLE.
  - A pending write that has not yet been performed is discarded.
  - Array contents are not cleared.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready=1`;
  - `stall=0`;
  - `resp_valid=0`;
  - `resp_rdata=0`;
  - `resp_err=0`;
  - counter 0.
- A request accepted at cycle T produces `resp_valid` at T+1+`WAIT_CYCLES` for a legal request, and at T+1 for an illegal one.
- `stall` is high in cycles T .. T+`WAIT_CYCLES`.
- Maximum throughput is one request per `WAIT_CYCLES`+2 cycles, since IDLE is mandatory between requests.
- The array uses a synchronous read port (registered output), so there is no combinational path from `req_addr` to `resp_rdata`.
- `req_ready` and `stall` are combinational from state and the request inputs only.

## Structure
- Shared package `mips_mem_pkg` holds:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - `WAIT_CNT_W = 4`;
  - `WORD_W = 32`.
- Sub-module `dmem_array`:
  - `DEPTH_WORDS` x 32;
  - single port, synchronous write enable, registered read;
  - instantiated once.
- The FSM, counter, error check and latches live in `dmem_responder`.

## Test plan
- Write then read, `WAIT_CYCLES=2`:
  - Write 0xDEADBEEF to 0x10 at T: `stall` high T..T+2, `resp_valid` at T+3 with `resp_err=0`.
  - Read 0x10 at T+4: `resp_rdata=0xDEADBEEF` at T+7.
- `WAIT_CYCLES=0`: read at T gives `resp_valid` at T+1 with `stall` high only in T; the next request is accepted at T+2.
- Misaligned read of 0x13: `resp_valid` and `resp_err=1` at T+1, `resp_rdata=0`, `stall` high one cycle.
- Out-of-range write:
  - Word index 1024 with `DEPTH_WORDS=1024` (byte address 0x1000): `resp_err=1`.
  - A subsequent read of 0x0 returns its prior contents unchanged.
- `req_rd` and `req_wr` both high at 0x20 with data 0x1234: `resp_err=1`, and a later read of 0x20 shows no write.
- Reset mid-operation:
  - Assert `rst` during WAIT of a write of 0xCAFEF00D to 0x40: next cycle IDLE, `stall=0`, `resp_valid=0`.
  - A later read of 0x40 returns the old value, not 0xCAFEF00D.
